// File: rtl/usb_fifo_bus_arbiter_pkg.sv
// usb_fifo_bus_arbiter_pkg: shared state encoding and bus constants for the USB FIFO arbiter
package usb_fifo_bus_arbiter_pkg;
    typedef enum logic [2:0] {
        ARB_IDLE,
        ARB_RX_OE,
        ARB_RX_READ,
        ARB_RX_END,
        ARB_TX_WRITE,
        ARB_TX_TURN
    } usb_arb_state_t;
    localparam logic [3:0] USB_BE_FULL = 4'hF;
endpackage

// File: rtl/usb_fifo_bus_arbiter_rx_skid.sv
// usb_fifo_bus_arbiter_rx_skid: small FIFO absorbing RX words with an occupancy count
module usb_fifo_bus_arbiter_rx_skid #(
    parameter int DEPTH = 4,
    parameter int W = 36,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic          valid,
    output logic [CW-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic wr, rd;
    assign wr = push & (count != FULL);
    assign rd = pop & (count != '0);
    assign valid = count != '0;
    assign dout = mem[rptr];
    // Storage carries no reset; occupancy is defined by pointers and count alone
    always_ff @(posedge clk)
        if (wr) mem[wptr] <= din;
    // Pointer and occupancy bookkeeping; pointers wrap since DEPTH is a power of two
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            count <= '0;
        end else begin
            wptr <= wptr + AW'(wr);
            rptr <= rptr + AW'(rd);
            count <= count + CW'(wr) - CW'(rd);
        end
endmodule

// File: rtl/usb_fifo_bus_arbiter.sv
// usb_fifo_bus_arbiter: time-shares the half-duplex FT601 bus between bounded RX and TX bursts
module usb_fifo_bus_arbiter
    import usb_fifo_bus_arbiter_pkg::*;
#(
    parameter int MAX_BURST = 16,
    parameter int RX_SKID_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] usb_data_i,
    output logic [31:0] usb_data_o,
    output logic        usb_data_oe,
    input  logic [3:0]  usb_be_i,
    output logic [3:0]  usb_be_o,
    input  logic        usb_rx_empty,
    input  logic        usb_tx_full,
    output logic        usb_rden_l,
    output logic        usb_outen_l,
    output logic        usb_wren_l,
    output logic [31:0] rx_data,
    output logic [3:0]  rx_be,
    output logic        rx_valid,
    input  logic        rx_ready,
    input  logic [31:0] tx_data,
    input  logic        tx_valid,
    output logic        tx_ready
);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int CW = $clog2(RX_SKID_DEPTH) + 1;
    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);
    localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);
    localparam logic [CW-1:0] CNT_PEND = CW'(RX_SKID_DEPTH - 2);
    localparam logic [CW-1:0] CNT_STOP = CW'(RX_SKID_DEPTH - 1);
    usb_arb_state_t state;
    logic [BW-1:0] burst;
    logic last_rx;
    logic [31:0] oreg;
    logic oreg_v;
    logic [CW-1:0] skid_count, skid_count_next;
    logic push, pop, rx_pend, tx_pend, accept, load, rx_stop;
    assign push = ~usb_rden_l & ~usb_rx_empty;
    assign pop = rx_valid & rx_ready;
    assign skid_count_next = skid_count + CW'(push) - CW'(pop);
    assign rx_pend = ~usb_rx_empty & (skid_count <= CNT_PEND);
    assign tx_pend = tx_valid;
    assign accept = ~usb_wren_l & ~usb_tx_full;
    assign tx_ready = (state == ARB_TX_WRITE) & (burst < BURST_MAX) & (~oreg_v | accept);
    assign load = tx_ready & tx_valid;
    assign rx_stop = usb_rx_empty | (push & (burst == BURST_LAST)) | (skid_count_next >= CNT_STOP);
    assign usb_wren_l = ~oreg_v;
    assign usb_data_o = oreg;
    assign usb_be_o = usb_data_oe ? USB_BE_FULL : 4'h0;
    usb_fifo_bus_arbiter_rx_skid #(.DEPTH(RX_SKID_DEPTH), .W(36)) u_skid (
        .clk(clk),
        .rst(rst),
        .push(push),
        .din({usb_be_i, usb_data_i}),
        .pop(pop),
        .dout({rx_be, rx_data}),
        .valid(rx_valid),
        .count(skid_count)
    );
    // Bus tenure sequencer; strobes and drive enable change only on state transitions
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= ARB_IDLE;
            burst <= '0;
            last_rx <= 1'b0;
            usb_rden_l <= 1'b1;
            usb_outen_l <= 1'b1;
            usb_data_oe <= 1'b0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    burst <= '0;
                    if (rx_pend & (~tx_pend | ~last_rx)) begin
                        state <= ARB_RX_OE;
                        usb_outen_l <= 1'b0;
                    end else if (tx_pend) begin
                        state <= ARB_TX_WRITE;
                        usb_data_oe <= 1'b1;
                    end
                end
                ARB_RX_OE: begin
                    state <= ARB_RX_READ;
                    usb_rden_l <= 1'b0;
                end
                ARB_RX_READ: begin
                    if (push) burst <= burst + BW'(1);
                    if (rx_stop) begin
                        state <= ARB_RX_END;
                        usb_rden_l <= 1'b1;
                        usb_outen_l <= 1'b1;
                    end
                end
                ARB_RX_END: begin
                    state <= ARB_IDLE;
                    last_rx <= 1'b1;
                end
                ARB_TX_WRITE: begin
                    if (load) burst <= burst + BW'(1);
                    if (~oreg_v & (~tx_valid | (burst == BURST_MAX))) begin
                        state <= ARB_TX_TURN;
                        usb_data_oe <= 1'b0;
                    end
                end
                ARB_TX_TURN: begin
                    state <= ARB_IDLE;
                    last_rx <= 1'b0;
                end
                default: state <= ARB_IDLE;
            endcase
        end
    // Output word register; a held word repeats on the pins until the FT601 accepts it
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            oreg <= '0;
            oreg_v <= 1'b0;
        end else if (load) begin
            oreg <= tx_data;
            oreg_v <= 1'b1;
        end else if (accept) begin
            oreg_v <= 1'b0;
        end
endmodule

// File: tb/tb_usb_fifo_bus_arbiter.sv
// tb_usb_fifo_bus_arbiter: mock FT601 plus scoreboard for the USB FIFO bus arbiter
module tb_usb_fifo_bus_arbiter;
    localparam int MB = 4;
    localparam int DEPTH = 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [31:0] usb_data_i = '0, usb_data_o, rx_data, tx_data = '0;
    logic [3:0] usb_be_i = '0, usb_be_o, rx_be;
    logic usb_data_oe, usb_rden_l, usb_outen_l, usb_wren_l, rx_valid, tx_ready;
    logic usb_rx_empty = 1'b1, usb_tx_full = 1'b0, rx_ready = 1'b1, tx_valid = 1'b0;
    logic tx_en = 1'b0;
    logic [35:0] rx_src[$], exp_rx[$];
    logic [31:0] tx_src[$], exp_tx[$];
    bit log_rx[$];
    int log_n[$];
    int checks = 0, errors = 0, cyc = 0;
    bit cap_f = 0, load_f = 0;
    bit prev_rden = 1, prev_outen = 1, prev_oe = 0;
    int outen_fall = -100, last_outen_low = -100, last_oe_cyc = -100;
    int rd_cnt = 0, wr_cnt = 0, wren_low_cnt = 0, acc_total = 0;

    usb_fifo_bus_arbiter #(.MAX_BURST(MB), .RX_SKID_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .usb_data_i(usb_data_i), .usb_data_o(usb_data_o), .usb_data_oe(usb_data_oe),
        .usb_be_i(usb_be_i), .usb_be_o(usb_be_o),
        .usb_rx_empty(usb_rx_empty), .usb_tx_full(usb_tx_full),
        .usb_rden_l(usb_rden_l), .usb_outen_l(usb_outen_l), .usb_wren_l(usb_wren_l),
        .rx_data(rx_data), .rx_be(rx_be), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Monitor: samples mid-cycle, checks invariants, pops scoreboards, logs tenures
    always @(negedge clk) begin
        cyc++;
        cap_f = !rst && !usb_rden_l && !usb_rx_empty;
        load_f = !rst && tx_valid && tx_ready;
        chk("no_contention", 64'(usb_data_oe & ~usb_outen_l), 0);
        chk("rden_implies_outen", 64'(~usb_rden_l & usb_outen_l), 0);
        if (rst) begin
            rd_cnt = 0;
            wr_cnt = 0;
        end else begin
            if (rx_valid && rx_ready) begin
                if (exp_rx.size() == 0) chk("rx_unexpected_word", {rx_be, rx_data}, 64'hDEAD);
                else chk("rx_word", {rx_be, rx_data}, exp_rx.pop_front());
            end
            if (!usb_wren_l && !usb_tx_full) begin
                acc_total++;
                if (exp_tx.size() == 0) chk("tx_unexpected_word", usb_data_o, 64'hDEAD);
                else chk("tx_word", usb_data_o, exp_tx.pop_front());
            end
            if (usb_data_oe) chk("tx_be", usb_be_o, 4'hF);
            if (cap_f) rd_cnt++;
            if (usb_data_oe && !usb_wren_l && !usb_tx_full) wr_cnt++;
            if (!usb_wren_l) wren_low_cnt++;
            if (prev_rden && !usb_rden_l) chk("outen_before_rden", 64'(cyc - outen_fall), 1);
            if (prev_outen && !usb_outen_l) begin
                outen_fall = cyc;
                chk("gap_oe_to_outen", 64'(cyc - last_oe_cyc >= 2), 1);
            end
            if (!prev_oe && usb_data_oe) chk("gap_outen_to_oe", 64'(cyc - last_outen_low >= 2), 1);
            if (!prev_outen && usb_outen_l) begin
                log_rx.push_back(1);
                log_n.push_back(rd_cnt);
                rd_cnt = 0;
            end
            if (prev_oe && !usb_data_oe) begin
                log_rx.push_back(0);
                log_n.push_back(wr_cnt);
                wr_cnt = 0;
            end
        end
        if (!usb_outen_l) last_outen_low = cyc;
        if (usb_data_oe) last_oe_cyc = cyc;
        prev_rden = usb_rden_l;
        prev_outen = usb_outen_l;
        prev_oe = usb_data_oe;
    end

    // Mock FT601 and TX source: consume on the edge, then present the next word
    always @(posedge clk) begin
        #1;
        if (cap_f && rx_src.size() != 0) void'(rx_src.pop_front());
        if (load_f && tx_src.size() != 0) exp_tx.push_back(tx_src.pop_front());
        usb_rx_empty = rx_src.size() == 0;
        {usb_be_i, usb_data_i} = (rx_src.size() != 0) ? rx_src[0] : 36'h0;
        tx_valid = tx_en && tx_src.size() != 0;
        tx_data = (tx_src.size() != 0) ? tx_src[0] : 32'h0;
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    function automatic bit idle_now();
        return rx_src.size() == 0 && exp_rx.size() == 0 && tx_src.size() == 0 &&
               exp_tx.size() == 0 && usb_outen_l && !usb_data_oe && usb_wren_l;
    endfunction

    task automatic wait_idle(input string name, input int budget);
        int i = 0;
        while (!idle_now() && i < budget) begin
            tick();
            i++;
        end
        if (!idle_now()) chk({name, "_timeout"}, 1, 0);
        tick(3);
    endtask

    task automatic apply_rst(input string name);
        rst = 1'b1;
        #1;
        chk({name, "_rden_l"}, usb_rden_l, 1);
        chk({name, "_outen_l"}, usb_outen_l, 1);
        chk({name, "_wren_l"}, usb_wren_l, 1);
        chk({name, "_oe"}, usb_data_oe, 0);
        rx_src.delete();
        exp_rx.delete();
        tx_src.delete();
        exp_tx.delete();
        tx_en = 0;
        usb_tx_full = 0;
        rx_ready = 1;
        tick(3);
        rst = 1'b0;
        log_rx.delete();
        log_n.delete();
        wren_low_cnt = 0;
        acc_total = 0;
        tick(2);
    endtask

    task automatic add_rx(input int n);
        for (int i = 0; i < n; i++) begin
            logic [35:0] w = {4'($urandom_range(1, 15)), $urandom()};
            rx_src.push_back(w);
            exp_rx.push_back(w);
        end
    endtask

    task automatic add_tx(input int n);
        for (int i = 0; i < n; i++) tx_src.push_back(($urandom() & 32'hFFFF0000) | 32'(i + acc_total * 0 + tx_src.size()));
    endtask

    task automatic scen1(input string name);
        apply_rst(name);
        add_rx(8);
        wait_idle({name, "_drain"}, 300);
        chk({name, "_wren_never_low"}, wren_low_cnt, 0);
        chk({name, "_idle_outen"}, usb_outen_l, 1);
        chk({name, "_idle_rden"}, usb_rden_l, 1);
        chk({name, "_tenures"}, log_n.size(), 8 / MB);
    endtask

    initial begin
        int occ, rl, tl, n, k;
        bit lr, go;
        tick(3);
        chk("reset_rden_l", usb_rden_l, 1);
        chk("reset_outen_l", usb_outen_l, 1);
        chk("reset_wren_l", usb_wren_l, 1);
        chk("reset_oe", usb_data_oe, 0);
        chk("reset_data_o", usb_data_o, 0);
        chk("reset_be_o", usb_be_o, 0);
        chk("reset_rx_valid", rx_valid, 0);
        chk("reset_tx_ready", tx_ready, 0);
        rst = 1'b0;
        tick(2);

        scen1("s1");

        apply_rst("s2");
        rx_ready = 0;
        add_rx(8);
        tick(40);
        occ = 8 - rx_src.size();
        chk("s2_reads_stopped", usb_rden_l, 1);
        chk("s2_skid_occupancy", 64'(occ >= DEPTH - 1 && occ <= DEPTH), 1);
        chk("s2_none_delivered", exp_rx.size(), 8);
        rx_ready = 1;
        wait_idle("s2_resume", 300);

        apply_rst("s3");
        add_rx(12);
        add_tx(16);
        tx_en = 1;
        wait_idle("s3_drain", 800);
        rl = 12;
        tl = 16;
        lr = 0;
        k = 0;
        while (rl > 0 || tl > 0) begin
            go = rl > 0 && (tl == 0 || !lr);
            n = go ? (rl < MB ? rl : MB) : (tl < MB ? tl : MB);
            if (k < log_n.size()) begin
                chk($sformatf("s3_tenure%0d_dir", k), log_rx[k], go);
                chk($sformatf("s3_tenure%0d_len", k), log_n[k], n);
            end
            if (go) rl -= n;
            else tl -= n;
            lr = go;
            k++;
        end
        chk("s3_tenure_count", log_n.size(), k);

        apply_rst("s4");
        add_tx(10);
        tx_en = 1;
        for (int i = 0; i < 400 && !idle_now(); i++) begin
            if (i % 3 == 2) usb_tx_full = !usb_tx_full;
            tick();
        end
        usb_tx_full = 0;
        wait_idle("s4_drain", 200);
        chk("s4_accepted", acc_total, 10);

        apply_rst("s5a");
        add_rx(8);
        for (int i = 0; i < 50 && usb_rden_l; i++) tick();
        chk("s5_reached_read", usb_rden_l, 0);
        tick();
        apply_rst("s5_mid_rx");
        add_tx(8);
        tx_en = 1;
        usb_tx_full = 1;
        for (int i = 0; i < 50 && usb_wren_l; i++) tick();
        chk("s5_reached_write", usb_wren_l, 0);
        tick(2);
        apply_rst("s5_mid_tx");
        scen1("s5_restart");

        apply_rst("s7");
        tx_en = 1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) add_rx(1);
            if ($urandom_range(0, 3) == 0) add_tx(1);
            rx_ready = $urandom_range(0, 3) != 0;
            usb_tx_full = $urandom_range(0, 3) == 0;
            tick();
        end
        rx_ready = 1;
        usb_tx_full = 0;
        wait_idle("s7_drain", 2000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
